pluck_ctrl: RTL

- Upstream control stage for one Karplus-Strong string voice.
- Turns a pluck request, a note select, a velocity and a mute request into the voice's `noteIn` (delay length), `pluck`, `gain` and `alpha` inputs.
- Times `pluck` so the full noise burst is loaded, enforces a low gap so the voice re-arms its pluck debounce, and ramps `gain` down on mute.
- Runs entirely at the audio sample rate.

---
 rtl/pluck_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pluck_ctrl.sv
// pluck_ctrl: drives note length, pluck, loop gain and noise alpha for one Karplus-Strong voice.
// Optional soft mute ramp when PLUCK_CTRL_SOFT_DAMP_EN is defined; otherwise mute silences in one sample.
module pluck_ctrl #(
`ifdef PLUCK_CTRL_SOFT_DAMP_EN
    parameter logic [17:0] GAIN_MUTE    = 18'h0_6000,
    parameter logic [17:0] DAMP_STEP    = 18'd64,
`endif
    parameter logic [17:0] GAIN_RING    = 18'h0_7FF0,
    parameter int unsigned PLUCK_MARGIN = 4,
    parameter int unsigned GAP          = 2
) (
    input  logic        audiolrclk,
    input  logic        reset,
    input  logic        trig,
    input  logic [3:0]  note_sel,
    input  logic [1:0]  vel,
    input  logic        mute,
    output logic [8:0]  note_out,
    output logic        pluck,
    output logic [17:0] gain,
    output logic [2:0]  alpha,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ARM, PLK, RING, DAMP} state_t;

    localparam logic [9:0] GAP_LAST = 10'(GAP - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [17:0] gain_d;
    logic [8:0]  note_d;
    logic [2:0]  alpha_d;
    logic        pend_q, pend_d;
    logic        arm_go;
    logic [3:0]  req_note;
    logic [1:0]  req_vel;
    logic [9:0]  plen;

    function automatic logic [8:0] note_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    note_lut = 9'd436;
            4'd1:    note_lut = 9'd412;
            4'd2:    note_lut = 9'd389;
            4'd3:    note_lut = 9'd367;
            4'd4:    note_lut = 9'd346;
            4'd5:    note_lut = 9'd327;
            4'd6:    note_lut = 9'd309;
            4'd7:    note_lut = 9'd291;
            4'd8:    note_lut = 9'd275;
            4'd9:    note_lut = 9'd259;
            4'd10:   note_lut = 9'd245;
            4'd11:   note_lut = 9'd231;
            4'd12:   note_lut = 9'd218;
            4'd13:   note_lut = 9'd206;
            4'd14:   note_lut = 9'd194;
            default: note_lut = 9'd183;
        endcase
    endfunction

    // Pluck spans the whole delay line plus margin so the full noise burst gets loaded.
    assign plen = {1'b0, note_out} + 10'(PLUCK_MARGIN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gain_d  = gain;
        note_d  = note_out;
        alpha_d = alpha;
        pend_d  = pend_q;
        arm_go  = 1'b0;
        case (state_q)
            IDLE: begin
                gain_d = '0;
                arm_go = pend_q;
            end
            ARM: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = PLK;
                    cnt_d   = '0;
                    gain_d  = GAIN_RING;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            PLK: begin
                if (cnt_q == plen - 10'd1) begin
                    if (pend_q) arm_go = 1'b1;
                    else        state_d = RING;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            RING: begin
                gain_d = GAIN_RING;
                // A trig arriving with mute wins: it becomes pending and re-arms next sample.
                if (pend_q) begin
                    arm_go = 1'b1;
                end else if (mute && !trig) begin
`ifdef PLUCK_CTRL_SOFT_DAMP_EN
                    state_d = DAMP;
`else
                    state_d = IDLE;
                    gain_d  = '0;
`endif
                end
            end
`ifdef PLUCK_CTRL_SOFT_DAMP_EN
            DAMP: begin
                if (pend_q) begin
                    arm_go = 1'b1;
                end else if (gain <= GAIN_MUTE + DAMP_STEP) begin
                    state_d = IDLE;
                    gain_d  = '0;
                end else begin
                    gain_d = gain - DAMP_STEP;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gain_d  = '0;
            end
        endcase
        if (arm_go) begin
            state_d = ARM;
            cnt_d   = '0;
            note_d  = note_lut(req_note);
            alpha_d = 3'd4 - {1'b0, req_vel};
            pend_d  = 1'b0;
        end
        if (trig) pend_d = 1'b1;
    end

    always_ff @(posedge audiolrclk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gain     <= '0;
            note_out <= 9'd436;
            alpha    <= 3'd4;
            pluck    <= 1'b0;
            busy     <= 1'b0;
            pend_q   <= 1'b0;
            req_note <= '0;
            req_vel  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gain     <= gain_d;
            note_out <= note_d;
            alpha    <= alpha_d;
            pluck    <= (state_d == PLK);
            busy     <= (state_d != IDLE);
            pend_q   <= pend_d;
            if (trig) begin
                req_note <= note_sel;
                req_vel  <= vel;
            end
        end
    end

endmodule
